// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  function automatic int unsigned rf_aw(input int unsigned nregs);
    return $clog2(nregs);
  endfunction

  // LSB position of port idx inside a packed bus of width-bit fields
  function automatic int unsigned rf_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets, accepted writeback clears, clear sequence wipes all.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NUM_WR = 1,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_all,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic [NUM_WR-1:0]    wb_en,
  input  logic [NUM_WR*AW-1:0] wb_addr,
  output logic [NREGS-1:0]     busy
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (clr_all) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (wb_en[i]) busy[wb_addr[rf_lsb(i, AW) +: AW]] <= 1'b0;
      end
      // Set after clear so a new producer issued this cycle stays outstanding
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to 0, busy scoreboard and clear sequencer.
// Optional REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_req,
  output logic                   clr_busy,
  input  logic [NUM_WR-1:0]      we,
  input  logic [NUM_WR*AW-1:0]   waddr,
  input  logic [NUM_WR*XLEN-1:0] wdata,
  input  logic [NUM_RD*AW-1:0]   raddr,
  output logic [NUM_RD*XLEN-1:0] rdata,
  output logic [NUM_RD-1:0]      rbusy,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_e         state;
  logic [AW-1:0]     cnt;
  logic [XLEN-1:0]   regs [NREGS];
  logic              idle;
  logic              clr_start;
  logic [NUM_WR-1:0] wr_ok;
  logic [NREGS-1:0]  busy;

  assign idle      = (state == RF_IDLE);
  assign clr_busy  = (state == RF_CLEAR);
  assign clr_start = idle && clr_req;

  always_comb begin
    wr_ok = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      wr_ok[i] = we[i] && idle && (waddr[rf_lsb(i, AW) +: AW] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RF_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (clr_req) begin
            state <= RF_CLEAR;
            cnt   <= AW'(1);
          end
        end
        RF_CLEAR: begin
          if (cnt == LAST) begin
            state <= RF_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: state <= RF_IDLE;
      endcase
    end
  end

  // Ascending port order makes the highest-index port win on address collisions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (state == RF_CLEAR) begin
      regs[cnt] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (wr_ok[i]) regs[waddr[rf_lsb(i, AW) +: AW]] <= wdata[rf_lsb(i, XLEN) +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NUM_WR(NUM_WR)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .clr_all (clr_start),
    .set_en  (iss_valid && idle && (iss_rd != '0)),
    .set_addr(iss_rd),
    .wb_en   (wr_ok),
    .wb_addr (waddr),
    .busy    (busy)
  );

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      logic [AW-1:0] ra;
      ra = raddr[rf_lsb(r, AW) +: AW];
      if (ra != '0) begin
        rdata[rf_lsb(r, XLEN) +: XLEN] = regs[ra];
        rbusy[r]                       = busy[ra];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned i = 0; i < NUM_WR; i++) begin
          if (wr_ok[i] && (waddr[rf_lsb(i, AW) +: AW] == ra)) begin
            rdata[rf_lsb(r, XLEN) +: XLEN] = wdata[rf_lsb(i, XLEN) +: XLEN];
            rbusy[r]                       = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read ports, 2 write ports), with an array-based reference model.
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   clr_req;
  logic                   clr_busy;
  logic [NUM_WR-1:0]      we;
  logic [NUM_WR*AW-1:0]   waddr;
  logic [NUM_WR*XLEN-1:0] wdata;
  logic [NUM_RD*AW-1:0]   raddr;
  logic [NUM_RD*XLEN-1:0] rdata;
  logic [NUM_RD-1:0]      rbusy;
  logic                   iss_valid;
  logic [AW-1:0]          iss_rd;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NUM_RD(NUM_RD),
    .NUM_WR(NUM_WR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd)
  );

  // Reference model: plain register array, busy flags, and remaining-clear bookkeeping
  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_busy [NREGS];
  bit              m_clear;
  int              m_idx;

  function automatic logic [AW-1:0] wa(input int p);
    return waddr[p*AW +: AW];
  endfunction
  function automatic logic [XLEN-1:0] wd(input int p);
    return wdata[p*XLEN +: XLEN];
  endfunction
  function automatic logic [AW-1:0] ra(input int r);
    return raddr[r*AW +: AW];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) begin
        m_reg[k]  = '0;
        m_busy[k] = 0;
      end
      m_clear = 0;
      m_idx   = 0;
    end else if (m_clear) begin
      m_reg[m_idx] = '0;
      m_idx++;
      if (m_idx == NREGS) m_clear = 0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (we[p] && wa(p) != 0) begin
          m_reg[wa(p)]  = wd(p);
          m_busy[wa(p)] = 0;
        end
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
      if (clr_req) begin
        m_clear = 1;
        m_idx   = 1;
        for (int k = 0; k < NREGS; k++) m_busy[k] = 0;
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_rdata(input int r);
    logic [XLEN-1:0] v;
    if (ra(r) == 0) return '0;
    v = m_reg[ra(r)];
`ifdef REGFILE_BYPASS_EN
    if (!m_clear)
      for (int p = 0; p < NUM_WR; p++)
        if (we[p] && wa(p) == ra(r)) v = wd(p);
`endif
    return v;
  endfunction

  function automatic bit exp_rbusy(input int r);
    bit b;
    if (ra(r) == 0) return 0;
    b = m_busy[ra(r)];
`ifdef REGFILE_BYPASS_EN
    if (!m_clear)
      for (int p = 0; p < NUM_WR; p++)
        if (we[p] && wa(p) == ra(r)) b = 0;
`endif
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NUM_RD; r++) begin
        chk("model_rdata", rdata[r*XLEN +: XLEN], exp_rdata(r));
        chk("model_rbusy", 32'(rbusy[r]), 32'(exp_rbusy(r)));
      end
      chk("model_clr_busy", 32'(clr_busy), 32'(m_clear));
    end
  end

  task automatic idle_in();
    clr_req = 0; we = '0; waddr = '0; wdata = '0; iss_valid = 0; iss_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int r, input logic [AW-1:0] a);
    raddr[r*AW +: AW] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1;
    raddr = '0;
    idle_in();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset state
    set_rd(0, 5); set_rd(1, 31);
    #1;
    chk("reset_rdata0", rdata[31:0], 32'h0);
    chk("reset_rdata1", rdata[63:32], 32'h0);
    chk("reset_rbusy", 32'(rbusy), 32'h0);
    chk("reset_clr_busy", 32'(clr_busy), 32'h0);

    // 1: write x5, read next cycle; write to x0 ignored
    set_wr(0, 5, 32'hDEADBEEF);
    step(); idle_in();
    chk("t1_x5", rdata[31:0], 32'hDEADBEEF);
    set_wr(0, 0, 32'h1); set_rd(1, 0);
    #1 chk("t1_x0_same", rdata[63:32], 32'h0);
    step(); idle_in();
    chk("t1_x0_after", rdata[63:32], 32'h0);

    // 2: same-cycle write/read of x7
    set_wr(0, 7, 32'h55);
    step(); idle_in();
    set_wr(1, 7, 32'h1234); set_rd(0, 7);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t2_bypass", rdata[31:0], 32'h1234);
`else
    chk("t2_old", rdata[31:0], 32'h55);
`endif
    step(); idle_in();
    chk("t2_next", rdata[31:0], 32'h1234);

    // 3: both ports write x3, port 1 wins
    set_wr(0, 3, 32'hAA); set_wr(1, 3, 32'hBB);
    step(); idle_in();
    set_rd(0, 3);
    #1 chk("t3_prio", rdata[31:0], 32'hBB);

    // 4: scoreboard set, clear, and set-wins collision
    iss_valid = 1; iss_rd = 9; set_rd(1, 9);
    step(); idle_in();
    chk("t4_set", 32'(rbusy[1]), 32'h1);
    set_wr(0, 9, 32'h99);
    step(); idle_in();
    chk("t4_clear", 32'(rbusy[1]), 32'h0);
    iss_valid = 1; iss_rd = 9; set_wr(1, 9, 32'h9A);
    step(); idle_in();
    chk("t4_setwins", 32'(rbusy[1]), 32'h1);
    chk("t4_data", rdata[63:32], 32'h9A);

    // 5: fill x1..x31, clear sequence; writes/issues/clr_req during clear are dropped
    for (int i = 1; i < NREGS; i++) begin
      set_wr(0, AW'(i), 32'h01010101 * i);
      step();
    end
    idle_in();
    set_rd(0, 4);
    #1 chk("t5_fill_x4", rdata[31:0], 32'h04040404);
    clr_req = 1;
    step();
    clr_req = 0;
    set_wr(0, 4, 32'hFFFF); iss_valid = 1; iss_rd = 6;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (clr_busy) cnt++;
      else if (cnt > 0) break;
      clr_req = (cnt == 5);
    end
    idle_in();
    chk("t5_clr_cycles", 32'(cnt), 32'd31);
    for (int a = 0; a < NREGS; a++) begin
      set_rd(0, AW'(a)); set_rd(1, AW'(NREGS - 1 - a));
      #1;
      chk("t5_zero0", rdata[31:0], 32'h0);
      chk("t5_zero1", rdata[63:32], 32'h0);
      chk("t5_busy", 32'(rbusy), 32'h0);
    end

    // 6: reset in the middle of a clear sequence
    @(posedge clk); #1;
    set_wr(0, 2, 32'h22); set_wr(1, 20, 32'h2020);
    step(); idle_in();
    clr_req = 1;
    step(); clr_req = 0;
    repeat (9) step();
    chk("t6_in_clear", 32'(clr_busy), 32'h1);
    set_rd(0, 20);
    #1 chk("t6_x20_pending", rdata[31:0], 32'h2020);
    reset = 1;
    #1;
    chk("t6_clr_busy_rst", 32'(clr_busy), 32'h0);
    chk("t6_x20_rst", rdata[31:0], 32'h0);
    @(negedge clk);
    reset = 0;
    set_wr(0, 11, 32'hCAFE); set_rd(1, 11);
    step(); idle_in();
    chk("t6_write_after", rdata[63:32], 32'hCAFE);
    chk("t6_idle", 32'(clr_busy), 32'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
